// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 4-channel round-robin arbiter.
//   state_t   : arbiter state (IDLE = output empty, HOLD = output word pending)
//   N_CH      : number of request channels
//   MAX_BURST : maximum consecutive words granted to one channel when
//               burst locking (RR_ARB_LOCK_EN) is compiled in
//   onehot4() : 2-bit channel index to 4-bit one-hot vector
package rr_arb_pkg;

    localparam int unsigned N_CH      = 4;
    localparam int unsigned MAX_BURST = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] k);
        return 4'b0001 << k;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker for 4 requesters.
//   req[3:0]  : raw request vector
//   mask[3:0] : requests to ignore this cycle
//   ptr[1:0]  : highest-priority channel; search runs ptr, ptr+1, ... mod 4
//   any       : at least one unmasked request present
//   idx[1:0]  : index of the winning channel (ptr when any = 0)
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [3:0] mask,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] idx
);

    logic [3:0] live;
    logic [1:0] cand;

    assign live = req & ~mask;

    // First live request found walking upward from ptr with wrap.
    always_comb begin
        any  = 1'b0;
        idx  = ptr;
        cand = ptr;
        for (int k = 0; k < int'(N_CH); k++) begin
            cand = ptr + 2'(k);
            if (!any && live[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arb_4x1.sv
// 4:1 round-robin arbiter with a one-word registered output stage.
// Optional feature: define RR_ARB_LOCK_EN to enable burst locking, where a
// channel that keeps req high is re-granted for up to MAX_BURST consecutive
// words before rotation is forced.
//   clk, rst       : clock, synchronous active-high reset
//   req[3:0]       : per-channel request
//   i0..i3 [W-1:0] : channel data, captured when the channel wins
//   sel[1:0]       : channel currently granted (downstream mux select)
//   gnt[3:0]       : one-hot acknowledge in the cycle the word is accepted
//   y[W-1:0]       : registered copy of the granted channel's data
//   y_valid        : y holds an unaccepted word
//   y_ready        : downstream accepts y when y_valid & y_ready
module rr_arb_4x1 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    output logic [1:0]   sel,
    output logic [3:0]   gnt,
    output logic [W-1:0] y,
    output logic         y_valid,
    input  logic         y_ready
);

    import rr_arb_pkg::*;

    state_t       state, state_n;
    logic [1:0]   ptr, ptr_n;
    logic [1:0]   sel_n;
    logic [W-1:0] y_n;

    logic         accept;
    logic         regrant;
    logic [1:0]   pick_ptr;
    logic [3:0]   pick_mask;
    logic         pick_any;
    logic [1:0]   pick_idx;
    logic [1:0]   data_idx;
    logic [W-1:0] data_mux;

`ifdef RR_ARB_LOCK_EN
    logic [1:0]   burst, burst_n;
`endif

    assign y_valid = (state == HOLD);

    // Reset suppresses the accept so a discarded word is never acknowledged.
    assign accept = y_valid & y_ready & ~rst;

    // gnt must coincide with the accept cycle, so it follows y_ready directly.
    assign gnt = accept ? onehot4(sel) : 4'b0000;

    // On accept, re-arbitrate from sel+1 with the accepted channel masked.
    assign pick_ptr  = accept ? (sel + 2'd1) : ptr;
    assign pick_mask = accept ? onehot4(sel) : 4'b0000;

`ifdef RR_ARB_LOCK_EN
    // Keep the same channel while it still requests, until the burst is full.
    assign regrant = accept & req[sel] & (burst != 2'(MAX_BURST - 1));
`else
    assign regrant = 1'b0;
`endif

    rr_pick4 u_pick (
        .req  (req),
        .mask (pick_mask),
        .ptr  (pick_ptr),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Plain 4:1 data selection by the channel being loaded into y.
    assign data_idx = regrant ? sel : pick_idx;

    always_comb begin
        case (data_idx)
            2'd0:    data_mux = i0;
            2'd1:    data_mux = i1;
            2'd2:    data_mux = i2;
            default: data_mux = i3;
        endcase
    end

    // Next-state and output-register load logic.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        y_n     = y;
`ifdef RR_ARB_LOCK_EN
        burst_n = burst;
`endif
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n = HOLD;
                    sel_n   = pick_idx;
                    y_n     = data_mux;
                end
            end
            HOLD: begin
                if (accept) begin
                    ptr_n = pick_ptr;
                    if (regrant) begin
                        y_n = data_mux;
`ifdef RR_ARB_LOCK_EN
                        burst_n = burst + 2'd1;
`endif
                    end else begin
`ifdef RR_ARB_LOCK_EN
                        burst_n = 2'd0;
`endif
                        if (pick_any) begin
                            sel_n = pick_idx;
                            y_n   = data_mux;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel   <= 2'd0;
            y     <= '0;
`ifdef RR_ARB_LOCK_EN
            burst <= 2'd0;
`endif
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            y     <= y_n;
`ifdef RR_ARB_LOCK_EN
            burst <= burst_n;
`endif
        end
    end

endmodule

// File: tb/tb_rr_arb_4x1.sv
// Self-checking bench for rr_arb_4x1: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the arbiter rules.
module tb_rr_arb_4x1;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [W-1:0] i0, i1, i2, i3;
    logic [1:0]   sel;
    logic [3:0]   gnt;
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_ready;

    always #5 clk = ~clk;

    rr_arb_4x1 #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .i0      (i0),
        .i1      (i1),
        .i2      (i2),
        .i3      (i3),
        .sel     (sel),
        .gnt     (gnt),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state.
    logic         m_valid = 1'b0;
    int           m_sel   = 0;
    int           m_ptr   = 0;
    int           m_burst = 0;
    logic [W-1:0] m_y     = '0;

    logic [3:0]   cap_gnt;
    logic [3:0]   exp_gnt;

    function automatic logic [W-1:0] chan(input int k);
        case (k)
            0:       return i0;
            1:       return i1;
            2:       return i2;
            default: return i3;
        endcase
    endfunction

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_edge();
        int win;
        logic [3:0] cand;
        if (rst) begin
            m_valid = 1'b0; m_sel = 0; m_ptr = 0; m_burst = 0; m_y = '0;
            return;
        end
        if (!m_valid) begin
            win = -1;
            for (int k = 0; k < 4; k++)
                if (win < 0 && req[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
            if (win >= 0) begin
                m_valid = 1'b1; m_sel = win; m_y = chan(win);
            end
            return;
        end
        if (!y_ready) return;
        m_ptr = (m_sel + 1) % 4;
`ifdef RR_ARB_LOCK_EN
        if (req[m_sel] && m_burst < 3) begin
            m_burst++;
            m_y = chan(m_sel);
            return;
        end
`endif
        m_burst = 0;
        cand = req;
        cand[m_sel] = 1'b0;
        win = -1;
        for (int k = 0; k < 4; k++)
            if (win < 0 && cand[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        if (win >= 0) begin
            m_sel = win; m_y = chan(win);
        end else begin
            m_valid = 1'b0;
        end
    endtask

    // Drive one cycle of inputs (starting at a falling edge), sample gnt
    // mid-cycle, clock the DUT and the model, and return at the next falling edge.
    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input logic [W-1:0] d2, input logic [W-1:0] d3,
                        input logic rdy);
        rst = r; req = rq; i0 = d0; i1 = d1; i2 = d2; i3 = d3; y_ready = rdy;
        #1;
        cap_gnt = gnt;
        exp_gnt = (m_valid && rdy && !r) ? 4'(1 << m_sel) : 4'b0000;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 4'b1111, rnd(), rnd(), rnd(), rnd(), 1'b1);
        step(1'b1, 4'b0000, rnd(), rnd(), rnd(), rnd(), 1'b1);
        n_checks++;
        if (y_valid !== 1'b0 || sel !== 2'd0 || y !== '0 || cap_gnt !== 4'b0000)
            $display("FAIL reset: y_valid=%b sel=%0d y=%h gnt=%b want 0/0/0/0000",
                     y_valid, sel, y, cap_gnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        step(1'b0, 4'b0010, rnd(), 8'h5a, rnd(), rnd(), 1'b0);
        n_checks++;
        if (y_valid !== 1'b1 || sel !== 2'd1 || y !== 8'h5a)
            $display("FAIL mid_hold_load: y_valid=%b sel=%0d y=%h want 1/1/5a", y_valid, sel, y);
        else n_pass++;
        step(1'b1, 4'b0010, rnd(), rnd(), rnd(), rnd(), 1'b0);
        n_checks++;
        if (y_valid !== 1'b0 || sel !== 2'd0 || cap_gnt !== 4'b0000)
            $display("FAIL mid_hold_rst: y_valid=%b sel=%0d gnt=%b want 0/0/0000", y_valid, sel, cap_gnt);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'b0000, rnd(), rnd(), rnd(), rnd(), 1'b1);
            n_checks++;
            if (cap_gnt !== 4'b0000 || y_valid !== 1'b0)
                $display("FAIL mid_hold_after[%0d]: gnt=%b y_valid=%b want 0000/0", k, cap_gnt, y_valid);
            else n_pass++;
        end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_sel [5];
        logic [3:0] exp_g   [5];
`ifdef RR_ARB_LOCK_EN
        exp_sel = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
        exp_g   = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_g   = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
        step(1'b1, 4'b0000, '0, '0, '0, '0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b1111, W'(0), W'(1), W'(0), W'(1), 1'b1);
            n_checks++;
            if (sel !== exp_sel[k] || cap_gnt !== exp_g[k] || y_valid !== 1'b1 ||
                y !== W'(exp_sel[k][0]))
                $display("FAIL rotation[%0d]: sel=%0d gnt=%b y=%h y_valid=%b want sel=%0d gnt=%b",
                         k, sel, cap_gnt, y, y_valid, exp_sel[k], exp_g[k]);
            else n_pass++;
        end
    endtask

`ifdef RR_ARB_LOCK_EN
    task automatic test_lock();
        logic [1:0] exp_sel [5];
        exp_sel = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        step(1'b1, 4'b0000, '0, '0, '0, '0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, (k == 0) ? 4'b0010 : 4'b1111, rnd(), rnd(), rnd(), rnd(), 1'b1);
            n_checks++;
            if (sel !== exp_sel[k])
                $display("FAIL lock[%0d]: sel=%0d want %0d", k, sel, exp_sel[k]);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_backpressure();
        step(1'b1, 4'b0000, '0, '0, '0, '0, 1'b0);
        step(1'b0, 4'b0100, rnd(), rnd(), W'(1), rnd(), 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'($urandom) | 4'b0100, rnd(), rnd(), W'(k % 2), rnd(), 1'b0);
            n_checks++;
            if (y !== W'(1) || y_valid !== 1'b1 || sel !== 2'd2 || cap_gnt !== 4'b0000)
                $display("FAIL backpressure[%0d]: y=%h y_valid=%b sel=%0d gnt=%b want 01/1/2/0000",
                         k, y, y_valid, sel, cap_gnt);
            else n_pass++;
        end
        step(1'b0, 4'b0000, rnd(), rnd(), rnd(), rnd(), 1'b1);
        n_checks++;
        if (cap_gnt !== 4'b0100 || y_valid !== 1'b0)
            $display("FAIL backpressure_release: gnt=%b y_valid=%b want 0100/0", cap_gnt, y_valid);
        else n_pass++;
    endtask

    task automatic test_ptr_wrap();
        step(1'b1, 4'b0000, '0, '0, '0, '0, 1'b0);
        step(1'b0, 4'b1000, rnd(), rnd(), rnd(), rnd(), 1'b1);
        n_checks++;
        if (sel !== 2'd3 || y_valid !== 1'b1)
            $display("FAIL wrap_first: sel=%0d y_valid=%b want 3/1", sel, y_valid);
        else n_pass++;
        step(1'b0, 4'b0001, rnd(), rnd(), rnd(), rnd(), 1'b1);
        n_checks++;
        if (cap_gnt !== 4'b1000 || sel !== 2'd0 || y_valid !== 1'b1)
            $display("FAIL wrap_second: gnt=%b sel=%0d y_valid=%b want 1000/0/1", cap_gnt, sel, y_valid);
        else n_pass++;
        step(1'b0, 4'b0000, rnd(), rnd(), rnd(), rnd(), 1'b1);
        n_checks++;
        if (cap_gnt !== 4'b0001 || y_valid !== 1'b0)
            $display("FAIL wrap_drain: gnt=%b y_valid=%b want 0001/0", cap_gnt, y_valid);
        else n_pass++;
        step(1'b0, 4'b1001, rnd(), rnd(), rnd(), rnd(), 1'b0);
        n_checks++;
        if (sel !== 2'd3 || y_valid !== 1'b1 || y !== m_y)
            $display("FAIL wrap_ptr1: sel=%0d y_valid=%b y=%h want 3/1/%h", sel, y_valid, y, m_y);
        else n_pass++;
    endtask

    task automatic test_idle();
        step(1'b1, 4'b0000, '0, '0, '0, '0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'b0000, rnd(), rnd(), rnd(), rnd(), 1'($urandom));
            n_checks++;
            if (y_valid !== 1'b0 || cap_gnt !== 4'b0000)
                $display("FAIL idle[%0d]: y_valid=%b gnt=%b want 0/0000", k, y_valid, cap_gnt);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 49) == 0), 4'($urandom), rnd(), rnd(), rnd(), rnd(),
                 1'($urandom_range(0, 3) != 0));
            n_checks++;
            if (cap_gnt !== exp_gnt || y_valid !== m_valid || sel !== 2'(m_sel) || y !== m_y) begin
                if (errs < 10)
                    $display("FAIL random[%0d]: gnt=%b y_valid=%b sel=%0d y=%h want %b/%b/%0d/%h",
                             k, cap_gnt, y_valid, sel, y, exp_gnt, m_valid, m_sel, m_y);
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; y_ready = 1'b0;
        i0 = '0; i1 = '0; i2 = '0; i3 = '0;
        @(negedge clk);
        test_reset();
        test_reset_mid_hold();
        test_rotation();
`ifdef RR_ARB_LOCK_EN
        test_lock();
`endif
        test_backpressure();
        test_ptr_wrap();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arb_4x1.md
RR_ARB_4X1 -- requirements
Module: rr_arb_4x1

Interface
REQ-001 Parameter W, default 1: data width of each channel and of y.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  per-channel request; req[k] asserted means channel k holds a word on ik.
REQ-005 i0, i1, i2, i3  input  W each  channel data; sampled only in the cycle the channel wins arbitration.
REQ-006 sel  output  2  index of the channel currently granted; drives a downstream 4:1 mux select.
REQ-007 gnt  output  4  one-hot, one-cycle acknowledge to channel sel in the cycle its word is accepted downstream.
REQ-008 y  output  W  registered copy of the granted channel's data.
REQ-009 y_valid  output  1  y holds an unaccepted word.
REQ-010 y_ready  input  1  downstream accepts y when y_valid and y_ready are both high.

Function
REQ-011 States: IDLE (y_valid=0) and HOLD (y_valid=1); no other states.
REQ-012 IDLE, req!=0: next cycle -> HOLD; sel = winner; y = i[winner] captured at that edge; latency one cycle from req to y_valid.
REQ-013 Winner: first asserted req searching upward modulo 4 from ptr (ptr, ptr+1, ptr+2, ptr+3).
REQ-014 ptr: 2-bit rotating priority pointer; on each accept ptr <= sel+1 (wraps 3 -> 0).
REQ-015 HOLD, no accept: sel, y, y_valid stable; req changes ignored; y never changes while y_valid=1 and y_ready=0.
REQ-016 HOLD, accept: gnt[sel]=1 that cycle only; if req (excluding the accepted channel, see REQ-024) is non-zero, re-arbitrate with the updated ptr in the same edge and stay in HOLD (back-to-back, no bubble); otherwise -> IDLE.
REQ-017 Accepted channel must drop or refresh its req the cycle after gnt; in the accept cycle its req bit is masked from re-arbitration.
REQ-018 req==0 in IDLE: stay IDLE, outputs unchanged except y_valid=0.
REQ-019 gnt is zero in every cycle without an accept; at most one bit set.
REQ-020 Sustained full load: each channel served exactly once per 4 accepts (rotation 0,1,2,3,0...).

Reset
REQ-021 rst high at a clock edge: state=IDLE, ptr=0, sel=0, y=0, y_valid=0, gnt=0; applies mid-HOLD; pending word discarded, no gnt issued.
REQ-022 First arbitration after reset release uses ptr=0.

Configuration
REQ-023 Macro RR_ARB_LOCK_EN selects burst locking.
REQ-024 With RR_ARB_LOCK_EN: on accept, if req[sel] still high, the same channel is re-granted (not masked) up to 4 consecutive words; the 4th accept forces rotation (ptr=sel+1, sel masked). A 2-bit burst counter, reset to 0, tracks this.
REQ-025 Without RR_ARB_LOCK_EN: pure rotation per REQ-016/017; no burst counter exists.

Structure
REQ-026 Shared package rr_arb_pkg: state enum (IDLE, HOLD), N_CH=4 constant, MAX_BURST=4 constant.
REQ-027 One sub-module rr_pick4: combinational, inputs req[3:0], mask[3:0], ptr[1:0]; outputs any, idx[1:0].
REQ-028 Data path uses a plain 4:1 selection of i0..i3 by the winner index.

Verification
REQ-029 Reset mid-HOLD: req=4'b0010, y_ready=0, rst pulse -> y_valid=0, sel=0, gnt=0 next cycle; no gnt ever for that word.
REQ-030 All request, y_ready=1, i0..i3=0,1,0,1 (W=1): sel sequence 0,1,2,3,0; gnt 0001,0010,0100,1000; y 0,1,0,1; y_valid continuously 1.
REQ-031 Backpressure: req=4'b0100, i2=1, y_ready=0 for 5 cycles, i2 toggled -> y=1 stable, gnt=0; y_ready=1 -> gnt=4'b0100 one cycle.
REQ-032 Pointer wrap: only req[3] then only req[0] -> grants 3 then 0; afterward req=4'b1001 -> grant 3 (ptr=1).
REQ-033 Lock on: req[1] held, all others high, y_ready=1 -> sel=1 for 4 accepts, then 2; lock off -> sel 1,2,3,0.
REQ-034 Idle: req=0 for 10 cycles -> y_valid=0, gnt=0 throughout.
